// File: rtl/decode_queue_stage.sv
// decode_queue_stage
//   Instruction-decode stage between fetch and register-read/execute.
//   Fetched words enter a small FIFO. The head entry is decoded
//   combinationally and then loaded into an output register. The condition
//   field is evaluated against live NZCV flags, which can be bypassed from
//   execute.
//
// Handshakes (valid/ready on both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holds its valid and payload until it sees that transfer. The
//   ready signal may depend on state, and on flush at the input side.
//   in_ready never depends on in_valid.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   in_valid/in_ready/in_instr   fetch side
//   flush             drops the queue and the output register at the next edge
//   cpsr              architectural CPSR (NZCV in [31:28])
//   flag_wr_valid/flag_wr_nzcv   flags being written by execute (bypass)
//   out_valid/out_ready          decode side
//   rm, rn, rd, shift, rotate, imm12, br_offset, cond   instruction fields
//   set_flags, is_imm, iclass, alu_ctl                  decode results
//   exec, undef       condition-pass / undefined indication
//   q_count           queue occupancy
//   stat_issued/stat_skipped/stat_undef   handshake counters
//
// Optional feature: define DECODE_STATS_EN to build the saturating 16-bit
// handshake counters. Without it, the stat ports are present and tied to 0.
module decode_queue_stage #(
  parameter int INSTR_W     = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int ALUCTL_W    = 11,
  localparam int PTR_W      = $clog2(QUEUE_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic                flush,
  input  logic [31:0]         cpsr,
  input  logic                flag_wr_valid,
  input  logic [3:0]          flag_wr_nzcv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          rm,
  output logic [3:0]          rn,
  output logic [3:0]          rd,
  output logic [7:0]          shift,
  output logic [3:0]          rotate,
  output logic [11:0]         imm12,
  output logic [23:0]         br_offset,
  output logic [3:0]          cond,
  output logic                set_flags,
  output logic                is_imm,
  output logic [2:0]          iclass,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                exec,
  output logic                undef,
  output logic [CNT_W-1:0]    q_count,
  output logic [15:0]         stat_issued,
  output logic [15:0]         stat_skipped,
  output logic [15:0]         stat_undef
);

  typedef enum logic [2:0] {
    IC_DP_REG = 3'd0,
    IC_DP_IMM = 3'd1,
    IC_B      = 3'd2,
    IC_BL     = 3'd3,
    IC_LDR    = 3'd4,
    IC_STR    = 3'd5,
    IC_UNDEF  = 3'd7
  } iclass_e;

  // ---------------- instruction queue ----------------
  logic [INSTR_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full, empty, push, load;
  logic               out_valid_q, out_valid_d;

  assign full     = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty    = (count_q == '0);
  // Ready is computed from full alone, so a pop in the same cycle does not
  // make room.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign load     = (!out_valid_q || out_ready) && !empty && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (load) rptr_d = rptr_q + PTR_W'(1);
      case ({push, load})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage does not need a reset: occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_instr;
  end

  // ---------------- decode of the head entry ----------------
  logic [31:0]         head_w;
  logic [7:0]          op;
  logic [2:0]          dec_iclass;
  logic [ALUCTL_W-1:0] dec_alu, dp_alu;
  logic [3:0]          dec_rm, dec_rd;
  logic                dec_sf, dec_imm, dp_ok;

  assign head_w = mem_q[rptr_q][31:0];
  assign op     = head_w[27:20];

  always_comb begin
    dec_iclass = IC_UNDEF;
    dec_alu    = '0;
    dec_rm     = head_w[3:0];
    dec_rd     = head_w[15:12];
    dec_sf     = 1'b0;
    dec_imm    = 1'b0;
    dp_ok      = 1'b1;
    dp_alu     = '0;
    // {I, opcode} selects the ALU operation. Only ADD/MOV/CMP exist in immediate form.
    case ({op[5], op[4:1]})
      5'b0_0000: dp_alu = ALUCTL_W'(3);   // AND
      5'b0_0001: dp_alu = ALUCTL_W'(5);   // EOR
      5'b0_0010: dp_alu = ALUCTL_W'(2);   // SUB
      5'b0_0100: dp_alu = ALUCTL_W'(0);   // ADD
      5'b0_1000: dp_alu = ALUCTL_W'(9);   // TST
      5'b0_1001: dp_alu = ALUCTL_W'(10);  // TEQ
      5'b0_1010: dp_alu = ALUCTL_W'(8);   // CMP
      5'b0_1100: dp_alu = ALUCTL_W'(4);   // ORR
      5'b0_1101: dp_alu = ALUCTL_W'(6);   // MOV
      5'b0_1110: dp_alu = ALUCTL_W'(11);  // BIC
      5'b0_1111: dp_alu = ALUCTL_W'(7);   // MVN
      5'b1_0100: dp_alu = ALUCTL_W'(1);   // ADD #imm
      5'b1_1101: dp_alu = ALUCTL_W'(12);  // MOV #imm
      5'b1_1010: dp_alu = ALUCTL_W'(13);  // CMP #imm
      default:   dp_ok  = 1'b0;
    endcase

    if (op[7:6] == 2'b00) begin
      if (dp_ok) begin
        dec_iclass = op[5] ? IC_DP_IMM : IC_DP_REG;
        dec_alu    = dp_alu;
        dec_sf     = op[0];
        dec_imm    = op[5];
      end
    end else if (op[7:4] == 4'b1010) begin
      dec_iclass = IC_B;
      dec_alu    = ALUCTL_W'(31);
    end else if (op[7:4] == 4'b1011) begin
      dec_iclass = IC_BL;
      dec_alu    = ALUCTL_W'(32);
    end else if (op[7:6] == 2'b01) begin
      if (op[0]) begin
        dec_iclass = IC_LDR;
        dec_alu    = ALUCTL_W'(41);
      end else begin
        // A store reads its data register, which sits in the Rd slot of the word.
        dec_iclass = IC_STR;
        dec_alu    = ALUCTL_W'(42);
        dec_rm     = head_w[15:12];
        dec_rd     = 4'd0;
      end
    end
  end

  // ---------------- output register ----------------
  logic [31:0]         instr_q;
  logic [2:0]          iclass_q;
  logic [ALUCTL_W-1:0] alu_q;
  logic [3:0]          rm_q, rd_q;
  logic                sf_q, imm_q;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (load)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      iclass_q    <= '0;
      alu_q       <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      sf_q        <= 1'b0;
      imm_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        instr_q  <= head_w;
        iclass_q <= dec_iclass;
        alu_q    <= dec_alu;
        rm_q     <= dec_rm;
        rd_q     <= dec_rd;
        sf_q     <= dec_sf;
        imm_q    <= dec_imm;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign rm        = rm_q;
  assign rd        = rd_q;
  assign rn        = instr_q[19:16];
  assign shift     = instr_q[11:4];
  assign rotate    = instr_q[11:8];
  assign imm12     = instr_q[11:0];
  assign br_offset = instr_q[23:0];
  assign cond      = instr_q[31:28];
  assign set_flags = sf_q;
  assign is_imm    = imm_q;
  assign iclass    = iclass_q;
  assign alu_ctl   = alu_q;
  assign q_count   = count_q;
  assign undef     = (iclass_q == IC_UNDEF);

  // ---------------- condition evaluation ----------------
  logic [3:0] nzcv;
  logic       f_n, f_z, f_c, f_v, cond_pass;
  logic       unused_cpsr_bits;

  assign unused_cpsr_bits = ^cpsr[27:0];
  // Flags being written this cycle override the architectural copy.
  assign nzcv = flag_wr_valid ? flag_wr_nzcv : cpsr[31:28];
  assign {f_n, f_z, f_c, f_v} = nzcv;

  always_comb begin
    cond_pass = 1'b0;
    case (instr_q[31:28])
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign exec = cond_pass && !undef;

  // ---------------- optional handshake statistics ----------------
`ifdef DECODE_STATS_EN
  logic [15:0] st_iss_q, st_skp_q, st_und_q;
  logic        hs;

  assign hs = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_iss_q <= '0;
      st_skp_q <= '0;
      st_und_q <= '0;
    end else if (hs) begin
      if (exec && st_iss_q != 16'hFFFF)             st_iss_q <= st_iss_q + 16'd1;
      if (!exec && !undef && st_skp_q != 16'hFFFF)  st_skp_q <= st_skp_q + 16'd1;
      if (undef && st_und_q != 16'hFFFF)            st_und_q <= st_und_q + 16'd1;
    end
  end

  assign stat_issued  = st_iss_q;
  assign stat_skipped = st_skp_q;
  assign stat_undef   = st_und_q;
`else
  assign stat_issued  = '0;
  assign stat_skipped = '0;
  assign stat_undef   = '0;
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
module tb_decode_queue_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_instr, cpsr;
  logic        flag_wr_valid;
  logic [3:0]  flag_wr_nzcv;
  logic        out_valid, out_ready;
  logic [3:0]  rm, rn, rd, rotate, cond;
  logic [7:0]  shift;
  logic [11:0] imm12;
  logic [23:0] br_offset;
  logic        set_flags, is_imm, exec, undef;
  logic [2:0]  iclass;
  logic [10:0] alu_ctl;
  logic [2:0]  q_count;
  logic [15:0] stat_issued, stat_skipped, stat_undef;

  decode_queue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .cpsr(cpsr),
    .flag_wr_valid(flag_wr_valid), .flag_wr_nzcv(flag_wr_nzcv),
    .out_valid(out_valid), .out_ready(out_ready),
    .rm(rm), .rn(rn), .rd(rd), .shift(shift), .rotate(rotate),
    .imm12(imm12), .br_offset(br_offset), .cond(cond),
    .set_flags(set_flags), .is_imm(is_imm), .iclass(iclass),
    .alu_ctl(alu_ctl), .exec(exec), .undef(undef), .q_count(q_count),
    .stat_issued(stat_issued), .stat_skipped(stat_skipped),
    .stat_undef(stat_undef)
  );

  // ---------------- records ----------------
  typedef struct packed {
    logic [2:0]  ic;
    logic [10:0] alu;
    logic [3:0]  rn, rd, rm, cnd;
    logic        ex, un, sf, im;
    logic [11:0] imm12;
    logic [7:0]  shift;
    logic [3:0]  rotate;
    logic [23:0] br;
  } obs_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  nzcv;
    logic        fwv;
    logic [3:0]  fwn;
    logic [2:0]  ic;
    logic [10:0] alu;
    logic [3:0]  rn, rd, rm;
    logic        ex, un, sf, im;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  obs_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   exp_iss = 0, exp_skp = 0, exp_und = 0;

  function automatic obs_t cur_obs();
    obs_t o;
    o = '{iclass, alu_ctl, rn, rd, rm, cond, exec, undef, set_flags, is_imm,
          imm12, shift, rotate, br_offset};
    return o;
  endfunction

  function automatic obs_t mk_exp(input vec_t v);
    obs_t o;
    o = '{v.ic, v.alu, v.rn, v.rd, v.rm, v.instr[31:28], v.ex, v.un, v.sf,
          v.im, v.instr[11:0], v.instr[11:4], v.instr[11:8], v.instr[23:0]};
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Samples on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got iclass %0d alu %0d expected none",
                 iclass, alu_ctl);
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        chk("scoreboard", 128'(cur_obs()), 128'(e));
        if (e.ex) exp_iss++;
        else if (!e.un) exp_skp++;
        if (e.un) exp_und++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [31:0] w, input obs_t e);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // ---------------- test ----------------
  initial begin
    obs_t snap;
    logic [15:0] u0;

    vecs[0]  = '{32'hE0875006, 4'h0, 1'b0, 4'h0, 3'd0, 11'd0,  4'd7,  4'd5, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h8A000003, 4'h2, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h8A000003, 4'h2, 1'b1, 4'h6, 3'd2, 11'd31, 4'd0,  4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h9A000003, 4'h6, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hE0A00000, 4'h0, 1'b0, 4'h0, 3'd7, 11'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'hE3A01005, 4'h0, 1'b0, 4'h0, 3'd1, 11'd12, 4'd0,  4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'hE2811001, 4'h0, 1'b0, 4'h0, 3'd1, 11'd1,  4'd1,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hE3500000, 4'h0, 1'b0, 4'h0, 3'd1, 11'd13, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{32'hE5912004, 4'h0, 1'b0, 4'h0, 3'd4, 11'd41, 4'd1,  4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hE5812008, 4'h0, 1'b0, 4'h0, 3'd5, 11'd42, 4'd1,  4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hEB000010, 4'h0, 1'b0, 4'h0, 3'd3, 11'd32, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0A000000, 4'h4, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h1A000000, 4'h4, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'hF0000000, 4'h0, 1'b0, 4'h0, 3'd0, 11'd3,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'hE1B00001, 4'h0, 1'b0, 4'h0, 3'd0, 11'd6,  4'd0,  4'd0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{32'hE2000001, 4'h0, 1'b0, 4'h0, 3'd7, 11'd0,  4'd0,  4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{32'hE8BD0000, 4'h0, 1'b0, 4'h0, 3'd7, 11'd0,  4'd13, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{32'hAA000000, 4'h9, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{32'hBA000000, 4'h9, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{32'hCA000000, 4'h0, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{32'hDA000000, 4'h8, 1'b0, 4'h0, 3'd2, 11'd31, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{32'h00224003, 4'h0, 1'b1, 4'h4, 3'd0, 11'd5,  4'd2,  4'd4, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0;
    cpsr = 32'h0; flag_wr_valid = 1'b0; flag_wr_nzcv = 4'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_q_count", 128'(q_count), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_fields", 128'(cur_obs()), 128'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Latency into an idle stage: registered after the second edge.
    out_ready = 1'b1;
    push_word(vecs[0].instr, mk_exp(vecs[0]));
    chk("lat_valid_edge1", 128'(out_valid), 128'(0));
    chk("lat_count_edge1", 128'(q_count), 128'(1));
    @(posedge clk); #1;
    chk("lat_valid_edge2", 128'(out_valid), 128'(1));
    wait_drain(20);

    // Table of decode / condition vectors, one at a time.
    for (int i = 0; i < NV; i++) begin
      cpsr          = {vecs[i].nzcv, 28'h0};
      flag_wr_valid = vecs[i].fwv;
      flag_wr_nzcv  = vecs[i].fwn;
      push_word(vecs[i].instr, mk_exp(vecs[i]));
      wait_drain(20);
    end
    cpsr = 32'h0; flag_wr_valid = 1'b0; flag_wr_nzcv = 4'h0;

    // Undefined instruction and its counter.
    u0 = stat_undef;
    push_word(vecs[4].instr, mk_exp(vecs[4]));
    wait_drain(20);
`ifdef DECODE_STATS_EN
    chk("stat_undef_step", 128'(stat_undef), 128'(u0 + 16'd1));
`else
    chk("stat_undef_tied", 128'(stat_undef), 128'(0));
`endif

    // Fill: queue full with output register held.
    out_ready = 1'b0;
    for (int i = 5; i < 10; i++) push_word(vecs[i].instr, mk_exp(vecs[i]));
    chk("fill_q_count", 128'(q_count), 128'(4));
    chk("fill_in_ready", 128'(in_ready), 128'(0));
    chk("fill_out_valid", 128'(out_valid), 128'(1));
    snap = cur_obs();
    repeat (2) @(posedge clk);
    #1;
    chk("stall_hold", 128'(cur_obs()), 128'(snap));
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_pending", 128'(exp_q.size()), 128'(0));
    chk("drain_out_valid", 128'(out_valid), 128'(0));
    chk("drain_q_count", 128'(q_count), 128'(0));

    // Flush with a word on offer.
    out_ready = 1'b0;
    for (int i = 5; i < 9; i++) push_word(vecs[i].instr, mk_exp(vecs[i]));
    chk("pre_flush_q_count", 128'(q_count), 128'(3));
    chk("pre_flush_out_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b1; in_instr = 32'hE3A0F0FF; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_q_count", 128'(q_count), 128'(0));
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_accept", 128'({out_valid, q_count}), 128'(0));

    // Counter totals (unaffected by the flush).
`ifdef DECODE_STATS_EN
    chk("stat_totals", 128'({stat_issued, stat_skipped, stat_undef}),
        128'({exp_iss[15:0], exp_skp[15:0], exp_und[15:0]}));
`else
    chk("stat_totals", 128'({stat_issued, stat_skipped, stat_undef}), 128'(0));
`endif

    // Asynchronous reset mid-stream.
    for (int i = 5; i < 8; i++) push_word(vecs[i].instr, mk_exp(vecs[i]));
    chk("pre_reset_q_count", 128'(q_count), 128'(2));
    chk("pre_reset_out_valid", 128'(out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 128'({out_valid, q_count}), 128'(0));
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_fields", 128'(cur_obs()), 128'(0));
    chk("post_reset_stats", 128'({stat_issued, stat_skipped, stat_undef}), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
